// File: rtl/golden_report_pkg.sv
// Shared types and helpers for the golden-nonce report path.
// GOLDEN_REPORT_SEQ_EN adds the SEQ state (sequence byte) to the frame FSM.
package golden_report_pkg;

  localparam int         FRAME_LEN_BASE = 6;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
`ifdef GOLDEN_REPORT_SEQ_EN
    ST_SEQ  = 3'd2,
`endif
    ST_B3   = 3'd3,
    ST_B2   = 3'd4,
    ST_B1   = 3'd5,
    ST_B0   = 3'd6,
    ST_CSUM = 3'd7
  } state_t;

  // Byte-wise XOR of the nonce, folded with an extra seed byte (0 when unused).
  function automatic logic [7:0] frame_csum(input logic [31:0] n, input logic [7:0] seed);
    return seed ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Generic register FIFO: push/pop take effect on posedge, dout shows the head combinationally.
// Push while full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
// Latency: one cycle from push to visibility at dout; storage array is not reset.
module nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Buffers golden-nonce pulses and sends each as a SYNC/N3..N0/CSUM byte frame (GOLDEN_REPORT_SEQ_EN adds a seq byte).
// Latency: pulse at edge E is popped at E+1; first frame byte is valid the cycle after E+1.
// Backpressure: tx_ready low stalls the frame with tx_data held; FIFO fills, then drops and sets sticky overflow.
module golden_nonce_reporter
  import golden_report_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nonce_valid,
  input  logic [31:0]                nonce_in,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       busy
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] nxt_nonce;
  logic [31:0] fifo_dout;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  seq;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (nonce_valid),
    .din   (nonce_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
`ifdef GOLDEN_REPORT_SEQ_EN
      ST_SYNC: if (tx_ready) state_nxt = ST_SEQ;
      ST_SEQ:  if (tx_ready) state_nxt = ST_B3;
`else
      ST_SYNC: if (tx_ready) state_nxt = ST_B3;
`endif
      ST_B3:   if (tx_ready) state_nxt = ST_B2;
      ST_B2:   if (tx_ready) state_nxt = ST_B1;
      ST_B1:   if (tx_ready) state_nxt = ST_B0;
      ST_B0:   if (tx_ready) state_nxt = ST_CSUM;
      ST_CSUM: begin
        // Chain straight into the next frame when one is waiting.
        if (tx_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_SYNC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      nxt_nonce <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) nxt_nonce <= fifo_dout;
      if (nonce_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

`ifdef GOLDEN_REPORT_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= 8'h00;
    end else if (state == ST_CSUM && tx_ready) begin
      seq <= seq + 8'd1;
    end
  end
`else
  assign seq = 8'h00;
`endif

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SYNC: tx_data = SYNC_BYTE;
`ifdef GOLDEN_REPORT_SEQ_EN
      ST_SEQ:  tx_data = seq;
`endif
      ST_B3:   tx_data = nxt_nonce[31:24];
      ST_B2:   tx_data = nxt_nonce[23:16];
      ST_B1:   tx_data = nxt_nonce[15:8];
      ST_B0:   tx_data = nxt_nonce[7:0];
      ST_CSUM: tx_data = frame_csum(nxt_nonce, seq);
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter: frame bytes, stalls, back-to-back frames, overflow, reset mid-frame.
// Expected frame bytes come from hand-computed checksums; GOLDEN_REPORT_SEQ_EN inserts the modelled seq byte.
module tb_golden_nonce_reporter;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          nonce_valid = 1'b0;
  logic [31:0]   nonce_in = 32'h0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          busy;

  int         total = 0;
  int         passed = 0;
  int         failed = 0;
  int         max_lvl = 0;
  logic [7:0] exp_seq = 8'h00;
  logic [7:0] byte_q[$];

  golden_nonce_reporter #(
    .DEPTH     (DEPTH),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nonce_valid (nonce_valid),
    .nonce_in    (nonce_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] n);
    nonce_in    = n;
    nonce_valid = 1'b1;
    @(negedge clk);
    nonce_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] n, input logic [7:0] csum);
    logic [7:0] cs;
    cs = csum;
    byte_q.push_back(8'hA5);
`ifdef GOLDEN_REPORT_SEQ_EN
    byte_q.push_back(exp_seq);
    cs = cs ^ exp_seq;
    exp_seq = exp_seq + 8'd1;
`endif
    byte_q.push_back(n[31:24]);
    byte_q.push_back(n[23:16]);
    byte_q.push_back(n[15:8]);
    byte_q.push_back(n[7:0]);
    byte_q.push_back(cs);
  endtask

  // Called on a negedge; compares every presented byte against the queue head.
  task automatic drain(input bit stall, input string tag);
    bit started;
    int cyc;
    started = 1'b0;
    cyc = 0;
    while (byte_q.size() != 0 && cyc < 400) begin
      tx_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (tx_valid) begin
        started = 1'b1;
        check({tag, "_byte"}, 32'(tx_data), 32'(byte_q[0]));
        if (tx_ready) void'(byte_q.pop_front());
      end else if (started && !stall) begin
        check({tag, "_gap"}, 32'(tx_valid), 32'd1);
      end
      cyc++;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check({tag, "_done"}, 32'(byte_q.size()), 32'd0);
    byte_q.delete();
  endtask

  initial begin
    int pre;
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single nonce, tx_ready high
    pulse(32'h00005302);
    check("t1_level_after_push", 32'(fifo_level), 32'd1);
    check("t1_valid_early", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_rise", 32'(tx_valid), 32'd1);
    check("t1_first_byte", 32'(tx_data), 32'hA5);
    check("t1_level_popped", 32'(fifo_level), 32'd0);
    push_frame(32'h00005302, 8'h51);
    drain(1'b0, "t1");
    check("t1_idle_valid", 32'(tx_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Same nonce with tx_ready pattern 1,0,0,...
    pulse(32'h00005302);
    @(negedge clk);
    push_frame(32'h00005302, 8'h51);
    drain(1'b1, "t2");
    @(negedge clk);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // Three consecutive pulses -> back-to-back frames
    max_lvl = 0;
    pulse(32'h11223344);
    pulse(32'hDEADBEEF);
    pulse(32'h00000001);
    push_frame(32'h11223344, 8'h44);
    push_frame(32'hDEADBEEF, 8'h22);
    push_frame(32'h00000001, 8'h01);
    drain(1'b0, "t3");
    check("t3_peak_level", 32'(max_lvl), 32'd2);
    check("t3_idle_valid", 32'(tx_valid), 32'd0);

    // Overflow with tx_ready held low
    pulse(32'h01020304);
    pulse(32'h10203040);
    pulse(32'hFF000000);
    pulse(32'h000000AA);
    pulse(32'h80808080);
    check("t4_level_full", 32'(fifo_level), 32'd4);
    check("t4_no_overflow_yet", 32'(overflow), 32'd0);
    pulse(32'hCAFEBABE);
    check("t4_level_still_full", 32'(fifo_level), 32'd4);
    check("t4_overflow_set", 32'(overflow), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    push_frame(32'h01020304, 8'h04);
    push_frame(32'h10203040, 8'h40);
    push_frame(32'hFF000000, 8'hFF);
    push_frame(32'h000000AA, 8'hAA);
    push_frame(32'h80808080, 8'h00);
    drain(1'b0, "t4");
    repeat (3) @(negedge clk);
    check("t4_no_sixth_frame", 32'(tx_valid), 32'd0);
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    check("t4_level_empty", 32'(fifo_level), 32'd0);

    // Reset in the middle of a frame
`ifdef GOLDEN_REPORT_SEQ_EN
    pre = 3;
`else
    pre = 2;
`endif
    pulse(32'h12345678);
    @(negedge clk);
    check("t5_sync", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    repeat (pre) @(negedge clk);
    tx_ready = 1'b0;
    check("t5_in_b2", 32'(tx_data), 32'h34);
    #2;
    rst_n = 1'b0;
    exp_seq = 8'h00;
    #1;
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_data", 32'(tx_data), 32'h00);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    check("t5_rst_level", 32'(fifo_level), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_stays_idle", 32'(tx_valid), 32'd0);
    pulse(32'h00000000);
    @(negedge clk);
    push_frame(32'h00000000, 8'h00);
    drain(1'b0, "t5");
    check("t5_final_busy", 32'(busy), 32'd0);
    check("t5_final_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
